// File: rtl/hc595_chain_driver.sv
// Serial frame driver for a chain of 74HC595 shift registers (SH_CP/DS/ST_CP); optional OE PWM under HC595_OE_PWM_EN.
// Latency: busy 2*CLK_DIV*8*NUM_CHIPS + CLK_DIV cycles from the accepting edge; data_out/register_clock/latch are registered.
// Backpressure: ready is high only in IDLE; a write while busy is dropped and raises a one-cycle overrun pulse.
module hc595_chain_driver #(
    parameter int NUM_CHIPS = 2,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [8*NUM_CHIPS-1:0] data_in,
    output logic                   ready,
    output logic                   overrun,
    output logic                   data_out,
    output logic                   register_clock,
    output logic                   latch,
    output logic                   oe_n,
    input  logic [7:0]             brightness
);
    localparam int FRAME_W = 8 * NUM_CHIPS;
    localparam int BIT_CW  = $clog2(FRAME_W + 1);
    localparam int PH_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PH_CW-1:0]  PH_LAST  = PH_CW'(CLK_DIV - 1);
    localparam logic [PH_CW-1:0]  PH_ONE   = PH_CW'(1);
    localparam logic [BIT_CW-1:0] BIT_FULL = BIT_CW'(FRAME_W);
    localparam logic [BIT_CW-1:0] BIT_ONE  = BIT_CW'(1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SHIFT_LO = 2'd1;
    localparam logic [1:0] SHIFT_HI = 2'd2;
    localparam logic [1:0] LATCH    = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PH_CW-1:0]   phase;
    logic [PH_CW-1:0]   phase_nxt;
    logic [BIT_CW-1:0]  bit_cnt;
    logic [BIT_CW-1:0]  bit_cnt_nxt;
    logic [FRAME_W-1:0] shift_q;
    logic [FRAME_W-1:0] shift_nxt;
    logic               accept;
    logic               phase_done;

    function automatic logic lead_bit(input logic [FRAME_W-1:0] v);
        return MSB_FIRST ? v[FRAME_W-1] : v[0];
    endfunction

    function automatic logic [FRAME_W-1:0] advance(input logic [FRAME_W-1:0] v);
        return MSB_FIRST ? {v[FRAME_W-2:0], 1'b0} : {1'b0, v[FRAME_W-1:1]};
    endfunction

    assign ready      = (state == IDLE);
    assign accept     = wr_en & ready;
    assign phase_done = (phase == PH_LAST);

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = SHIFT_LO;
                    phase_nxt   = '0;
                    bit_cnt_nxt = BIT_FULL;
                    shift_nxt   = data_in;
                end
            end
            SHIFT_LO: begin
                if (phase_done) begin
                    state_nxt = SHIFT_HI;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + PH_ONE;
                end
            end
            SHIFT_HI: begin
                // The register advances on the edge that drops register_clock, so DS
                // only moves while SH_CP is low.
                if (phase_done) begin
                    phase_nxt   = '0;
                    bit_cnt_nxt = bit_cnt - BIT_ONE;
                    shift_nxt   = advance(shift_q);
                    state_nxt   = (bit_cnt == BIT_ONE) ? LATCH : SHIFT_LO;
                end else begin
                    phase_nxt = phase + PH_ONE;
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                end else begin
                    phase_nxt = phase + PH_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Pin outputs are decoded from the next state and registered so the chain sees glitch-free edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            phase          <= '0;
            bit_cnt        <= '0;
            shift_q        <= '0;
            data_out       <= 1'b0;
            register_clock <= 1'b0;
            latch          <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_nxt;
            phase          <= phase_nxt;
            bit_cnt        <= bit_cnt_nxt;
            shift_q        <= shift_nxt;
            register_clock <= (state_nxt == SHIFT_HI);
            latch          <= (state_nxt == LATCH);
            data_out       <= ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI))
                              ? lead_bit(shift_nxt) : 1'b0;
            overrun        <= wr_en & ~ready;
        end
    end

`ifdef HC595_OE_PWM_EN
    logic [7:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign oe_n = ~(pwm_cnt < brightness);
`else
    logic unused_brightness;

    assign unused_brightness = ^brightness;
    assign oe_n              = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Directed bench for hc595_chain_driver: two instances (1 chip / CLK_DIV 2 / MSB first, 2 chips / CLK_DIV 3 / LSB first).
// Expected serial bits are queued when a frame is driven and popped at each register_clock rise.
module tb_hc595_chain_driver;
    logic        clk;
    logic        rst_n;
    logic [7:0]  bright;

    logic        wr_a, rdy_a, ovr_a, do_a, rc_a, lat_a, oe_a;
    logic [7:0]  din_a;
    logic        wr_b, rdy_b, ovr_b, do_b, rc_b, lat_b, oe_b;
    logic [15:0] din_b;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic q_a [$];
    logic q_b [$];

    int   rises      [2] = '{0, 0};
    int   latches    [2] = '{0, 0};
    int   lat_w      [2] = '{0, 0};
    int   last_lat_w [2] = '{0, 0};
    int   busy       [2] = '{0, 0};
    int   last_busy  [2] = '{0, 0};
    int   idle       [2] = '{0, 0};
    int   last_idle  [2] = '{0, 0};
    int   ovr_cnt    [2] = '{0, 0};
    int   viol       [2] = '{0, 0};
    logic prev_rc    [2] = '{1'b0, 1'b0};
    logic prev_do    [2] = '{1'b0, 1'b0};

    hc595_chain_driver #(.NUM_CHIPS(1), .CLK_DIV(2), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_a), .data_in(din_a), .ready(rdy_a),
        .overrun(ovr_a), .data_out(do_a), .register_clock(rc_a), .latch(lat_a),
        .oe_n(oe_a), .brightness(bright)
    );

    hc595_chain_driver #(.NUM_CHIPS(2), .CLK_DIV(3), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_b), .data_in(din_b), .ready(rdy_b),
        .overrun(ovr_b), .data_out(do_b), .register_clock(rc_b), .latch(lat_b),
        .oe_n(oe_b), .brightness(bright)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon(input int k, input logic rc, input logic dout, input logic lat,
                       input logic rdy, input logic ovr, input logic have, input logic eb);
        if (rc && !prev_rc[k]) begin
            rises[k]++;
            chk("rise_has_expected_bit", 32'(have), 32'd1);
            if (have) chk("bit_at_rise", 32'(dout), 32'(eb));
        end
        if (rc && prev_rc[k] && (dout !== prev_do[k])) viol[k]++;
        if (rc && lat) viol[k]++;
        if (lat) begin
            lat_w[k]++;
        end else if (lat_w[k] > 0) begin
            last_lat_w[k] = lat_w[k];
            latches[k]++;
            lat_w[k] = 0;
        end
        if (!rdy) begin
            busy[k]++;
            if (idle[k] > 0) begin last_idle[k] = idle[k]; idle[k] = 0; end
        end else begin
            idle[k]++;
            if (busy[k] > 0) begin last_busy[k] = busy[k]; busy[k] = 0; end
        end
        if (ovr) ovr_cnt[k]++;
        prev_rc[k] = rc;
        prev_do[k] = dout;
    endtask

    always @(negedge clk) begin
        logic h, e;
        h = 1'b0;
        e = 1'b0;
        if (rc_a && !prev_rc[0] && q_a.size() > 0) begin h = 1'b1; e = q_a.pop_front(); end
        mon(0, rc_a, do_a, lat_a, rdy_a, ovr_a, h, e);
    end

    always @(negedge clk) begin
        logic h, e;
        h = 1'b0;
        e = 1'b0;
        if (rc_b && !prev_rc[1] && q_b.size() > 0) begin h = 1'b1; e = q_b.pop_front(); end
        mon(1, rc_b, do_b, lat_b, rdy_b, ovr_b, h, e);
    end

    task automatic send(input int k, input logic [15:0] d);
        if (k == 0) begin
            for (int i = 7; i >= 0; i--) q_a.push_back(d[i]);
            wr_a  = 1'b1;
            din_a = d[7:0];
        end else begin
            for (int i = 0; i < 16; i++) q_b.push_back(d[i]);
            wr_b  = 1'b1;
            din_b = d;
        end
        @(posedge clk); #1;
        wr_a = 1'b0;
        wr_b = 1'b0;
        chk("accept_drops_ready", 32'((k == 0) ? rdy_a : rdy_b), 32'd0);
    endtask

    task automatic wait_ready(input int k, input int bound);
        int   n;
        logic r;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            r = (k == 0) ? rdy_a : rdy_b;
        end while (!r && n < bound);
        chk("ready_within_bound", 32'(r), 32'd1);
        @(negedge clk); #1;
    endtask

    initial begin
        int n;
        int lows;
        int exp_lo;
        rst_n  = 1'b0;
        wr_a   = 1'b0;
        din_a  = '0;
        wr_b   = 1'b0;
        din_b  = '0;
        bright = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready_a", 32'(rdy_a), 32'd1);
        chk("rst_ready_b", 32'(rdy_b), 32'd1);
        chk("rst_data_out", 32'(do_a), 32'd0);
        chk("rst_register_clock", 32'(rc_a), 32'd0);
        chk("rst_latch", 32'(lat_a), 32'd0);
        chk("rst_overrun", 32'(ovr_a), 32'd0);
`ifdef HC595_OE_PWM_EN
        chk("rst_oe_n", 32'(oe_a), 32'd1);
`else
        chk("rst_oe_n", 32'(oe_a), 32'd0);
`endif

        // First write on the first edge after release, 0xA5 MSB first
        rst_n = 1'b1;
        send(0, 16'h00A5);
        wait_ready(0, 100);
        chk("a5_busy_cycles", last_busy[0], 32'd34);
        chk("a5_rises", rises[0], 32'd8);
        chk("a5_latch_pulses", latches[0], 32'd1);
        chk("a5_latch_width", last_lat_w[0], 32'd2);
        chk("a5_queue_empty", q_a.size(), 32'd0);

        // Two chips, LSB first, 0x8001
        send(1, 16'h8001);
        wait_ready(1, 300);
        chk("b_busy_cycles", last_busy[1], 32'd99);
        chk("b_rises", rises[1], 32'd16);
        chk("b_latch_pulses", latches[1], 32'd1);
        chk("b_latch_width", last_lat_w[1], 32'd3);
        chk("b_queue_empty", q_b.size(), 32'd0);

        // Overrun: 0xFF at cycle 5 of a busy frame is dropped
        rises[0] = 0; latches[0] = 0; ovr_cnt[0] = 0;
        send(0, 16'h003C);
        repeat (4) begin @(posedge clk); #1; end
        wr_a  = 1'b1;
        din_a = 8'hFF;
        @(posedge clk); #1;
        wr_a  = 1'b0;
        wait_ready(0, 100);
        chk("ovr_pulses", ovr_cnt[0], 32'd1);
        chk("ovr_rises", rises[0], 32'd8);
        chk("ovr_latch_pulses", latches[0], 32'd1);
        repeat (20) begin @(posedge clk); #1; end
        chk("ovr_no_second_frame_ready", 32'(rdy_a), 32'd1);
        chk("ovr_no_second_frame_rises", rises[0], 32'd8);

        // wr_en held high across two frames
        rises[0] = 0; latches[0] = 0;
        send(0, 16'h0096);
        wr_a  = 1'b1;
        din_a = 8'h4B;
        for (int i = 7; i >= 0; i--) q_a.push_back(din_a[i]);
        wait_ready(0, 100);
        chk("b2b_first_latches", latches[0], 32'd1);
        chk("b2b_first_rises", rises[0], 32'd8);
        @(posedge clk); #1;
        wr_a = 1'b0;
        chk("b2b_second_accepted", 32'(rdy_a), 32'd0);
        @(negedge clk); #1;
        chk("b2b_idle_cycles", last_idle[0], 32'd1);
        wait_ready(0, 100);
        chk("b2b_rises", rises[0], 32'd16);
        chk("b2b_latches", latches[0], 32'd2);
        chk("b2b_queue_empty", q_a.size(), 32'd0);

        // Reset after three bits aborts without a latch pulse
        rises[0] = 0; latches[0] = 0;
        send(0, 16'h00C3);
        n = 0;
        while (rises[0] < 3 && n < 100) begin @(negedge clk); #1; n++; end
        chk("abort_three_bits_seen", rises[0], 32'd3);
        chk("abort_rc_high_before", 32'(rc_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rc_async", 32'(rc_a), 32'd0);
        chk("abort_latch_async", 32'(lat_a), 32'd0);
        chk("abort_ready_async", 32'(rdy_a), 32'd1);
        repeat (2) begin @(posedge clk); #1; end
        chk("abort_no_latch", latches[0], 32'd0);
        q_a.delete();
        rises[0] = 0;
        rst_n = 1'b1;
        send(0, 16'h005A);
        wait_ready(0, 100);
        chk("abort_refill_rises", rises[0], 32'd8);
        chk("abort_refill_latches", latches[0], 32'd1);
        chk("abort_refill_queue_empty", q_a.size(), 32'd0);

        // Output-enable behaviour over full 256-cycle windows
        for (int b = 0; b < 3; b++) begin
            bright = (b == 0) ? 8'd64 : (b == 1) ? 8'd0 : 8'd255;
`ifdef HC595_OE_PWM_EN
            exp_lo = int'(bright);
`else
            exp_lo = 256;
`endif
            @(negedge clk);
            lows = 0;
            repeat (256) begin
                @(negedge clk);
                if (oe_a === 1'b0) lows++;
            end
            chk("oe_low_cycles", lows, exp_lo);
        end

        chk("a_dout_stable_latch_clean", viol[0], 32'd0);
        chk("b_dout_stable_latch_clean", viol[1], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
